// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module  : lfsr_pkg
// Purpose : Shared types and the single-step LFSR function for lfsr_gen.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

   typedef enum logic [0:0] {
      LFSR_FIB = 1'b0,
      LFSR_GAL = 1'b1
   } lfsr_mode_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } meas_state_e;

   // Operates on a 32-bit container; only the low 'width' bits are meaningful.
   function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                             input logic [31:0] tap,
                                             input lfsr_mode_e  mode,
                                             input int unsigned width);
      logic [31:0] mask;
      logic [31:0] shifted;
      mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      shifted = (state << 1) & mask;
      if (mode == LFSR_FIB) begin
         return shifted | {31'd0, ^(state & tap & mask)};
      end
      return shifted ^ (state[width-1] ? (tap & mask) : 32'd0);
   endfunction

endpackage : lfsr_pkg

`default_nettype wire

// File: rtl/lfsr_core.sv
// ============================================================================
// Module  : lfsr_core
// Purpose : LFSR state, tap and mode registers with next-state logic.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int          WIDTH        = 8,
   parameter logic [31:0] DEFAULT_SEED = 32'h01,
   parameter logic [31:0] DEFAULT_TAP  = 32'h0E
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_seed,
   input  logic [WIDTH-1:0] load_tap,
   input  lfsr_mode_e       load_mode,
   input  logic             step,
   output logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] next
);

   localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_state;
   logic [WIDTH-1:0] r_tap;
   lfsr_mode_e       r_mode;
   logic [WIDTH-1:0] w_next;

   assign w_next = WIDTH'(lfsr_next(32'(r_state), 32'(r_tap), r_mode, WIDTH));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= DEFAULT_SEED[WIDTH-1:0];
         r_tap   <= DEFAULT_TAP[WIDTH-1:0];
         r_mode  <= LFSR_FIB;
      end else if (load) begin
         // An all-zero seed would lock the register, so it is forced to 1.
         r_state <= (load_seed == '0) ? c_one : load_seed;
         r_tap   <= load_tap;
         r_mode  <= load_mode;
      end else if (step) begin
         r_state <= w_next;
      end
   end

   assign state = r_state;
   assign next  = w_next;

endmodule : lfsr_core

`default_nettype wire

// File: rtl/lfsr_gen.sv
// ============================================================================
// Module  : lfsr_gen
// Purpose : PRBS source with config load, valid/ready stream, period measure.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int          WIDTH        = 8,
   parameter logic [31:0] DEFAULT_SEED = 32'h01,
   parameter logic [31:0] DEFAULT_TAP  = 32'h0E
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cfg_load,
   input  logic [WIDTH-1:0] cfg_seed,
   input  logic [WIDTH-1:0] cfg_tap,
   input  logic             cfg_mode,
   output logic             cfg_ready,
   output logic             seed_err,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   input  logic             meas_start,
   output logic             meas_busy,
   output logic             meas_done,
   output logic             meas_timeout,
   output logic [WIDTH:0]   period
);

   localparam logic [WIDTH:0] c_cnt_limit = {1'b1, {WIDTH{1'b0}}};

   meas_state_e      r_fsm;
   meas_state_e      w_fsm_nxt;
   logic [WIDTH-1:0] r_ref;
   logic [WIDTH:0]   r_cnt;
   logic [WIDTH:0]   r_period;
   logic             r_done;
   logic             r_timeout;
   logic             r_seed_err;

   logic             w_load;
   logic             w_start;
   logic             w_step;
   logic             w_hit;
   logic             w_to;
   logic [WIDTH:0]   w_cnt_inc;
   logic [WIDTH-1:0] w_state;
   logic [WIDTH-1:0] w_next;

   lfsr_core #(
      .WIDTH        (WIDTH),
      .DEFAULT_SEED (DEFAULT_SEED),
      .DEFAULT_TAP  (DEFAULT_TAP)
   ) u_core (
      .clk       (clk),
      .resetn    (resetn),
      .load      (w_load),
      .load_seed (cfg_seed),
      .load_tap  (cfg_tap),
      .load_mode (lfsr_mode_e'(cfg_mode)),
      .step      (w_step),
      .state     (w_state),
      .next      (w_next)
   );

   assign w_cnt_inc = r_cnt + 1'b1;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      w_load    = 1'b0;
      w_start   = 1'b0;
      w_step    = 1'b0;
      w_hit     = 1'b0;
      w_to      = 1'b0;
      case (r_fsm)
         IDLE: begin
            if (cfg_load) begin
               w_load = 1'b1;
            end else if (meas_start) begin
               w_start   = 1'b1;
               w_fsm_nxt = RUN;
            end else begin
               w_step = dout_ready;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (w_next == r_ref) begin
               w_hit     = 1'b1;
               w_fsm_nxt = IDLE;
            end else if (w_cnt_inc == c_cnt_limit) begin
               w_to      = 1'b1;
               w_fsm_nxt = IDLE;
            end
         end
         default: w_fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ref      <= '0;
         r_cnt      <= '0;
         r_period   <= '0;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
         r_seed_err <= 1'b0;
      end else begin
         r_done     <= w_hit;
         r_timeout  <= w_to;
         r_seed_err <= w_load && (cfg_seed == '0);
         if (w_start) begin
            r_ref <= w_state;
            r_cnt <= '0;
         end else if (r_fsm == RUN) begin
            r_cnt <= w_cnt_inc;
         end
         if (w_hit) begin
            r_period <= w_cnt_inc;
         end
      end
   end

   assign dout         = w_state;
   assign cfg_ready    = (r_fsm == IDLE);
   assign dout_valid   = (r_fsm == IDLE);
   assign meas_busy    = (r_fsm == RUN);
   assign meas_done    = r_done;
   assign meas_timeout = r_timeout;
   assign seed_err     = r_seed_err;
   assign period       = r_period;

endmodule : lfsr_gen

`default_nettype wire
